// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154b_branch_resolve_pkg
// Shared definitions for the execute-side branch resolution block:
//   - RISC-V control-flow opcodes decoded in Execute
//   - op_class_t / classify_op() : opcode -> control-flow class
//   - payload_width()            : bit width of one fetch-prediction payload
// ---------------------------------------------------------------------------
package ucsbece154b_branch_resolve_pkg;

  localparam logic [6:0] instr_branch_op = 7'b1100011;
  localparam logic [6:0] instr_jal_op    = 7'b1101111;
  localparam logic [6:0] instr_jalr_op   = 7'b1100111;

  typedef enum logic [1:0] {
    OP_OTHER  = 2'd0,
    OP_BRANCH = 2'd1,
    OP_JUMP   = 2'd2
  } op_class_t;

  function automatic op_class_t classify_op(input logic [6:0] op);
    case (op)
      instr_branch_op:             return OP_BRANCH;
      instr_jal_op, instr_jalr_op: return OP_JUMP;
      default:                     return OP_OTHER;
    endcase
  endfunction

  // Payload = {pc, predtaken, predtarget, btbhit, phtidx}.
  function automatic int payload_width(input int ghr_bits);
    return 32 + 1 + 32 + 1 + ghr_bits;
  endfunction

endpackage

// File: rtl/ucsbece154b_branch_resolve_if.sv
// ---------------------------------------------------------------------------
// ucsbece154b_branch_resolve_if
// Bundles every non-clock/reset signal of the branch resolve block.
//   Fetch side   : pc_f_i, predtaken_f_i, predtarget_f_i, btbhit_f_i, phtidx_f_i
//   Hazard side  : StallD_i, FlushD_i, FlushE_i
//   Execute side : op_e_i, taken_e_i, target_e_i
//   Predictor    : BTB*_o, PHT*_o, GHRreset_o
//   Redirect     : Mispredict_o, PCcorrect_o
//   Statistics   : branchcnt_o, mispredcnt_o
// master drives the pipeline inputs; slave is the resolve block itself.
// ---------------------------------------------------------------------------
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int CNT_WIDTH       = 32
);
  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  logic [31:0]             pc_f_i;
  logic                    predtaken_f_i;
  logic [31:0]             predtarget_f_i;
  logic                    btbhit_f_i;
  logic [NUM_GHR_BITS-1:0] phtidx_f_i;

  logic                    StallD_i;
  logic                    FlushD_i;
  logic                    FlushE_i;

  logic [6:0]              op_e_i;
  logic                    taken_e_i;
  logic [31:0]             target_e_i;

  logic [BTB_IDX_W-1:0]    BTBwriteaddress_o;
  logic [31:0]             BTBwritedata_o;
  logic                    BTB_we_o;
  logic                    PHTwe_o;
  logic                    PHTincrement_o;
  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
  logic                    GHRreset_o;
  logic                    Mispredict_o;
  logic [31:0]             PCcorrect_o;
  logic [CNT_WIDTH-1:0]    branchcnt_o;
  logic [CNT_WIDTH-1:0]    mispredcnt_o;

  modport master (
    output pc_f_i, predtaken_f_i, predtarget_f_i, btbhit_f_i, phtidx_f_i,
    output StallD_i, FlushD_i, FlushE_i,
    output op_e_i, taken_e_i, target_e_i,
    input  BTBwriteaddress_o, BTBwritedata_o, BTB_we_o,
    input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
    input  Mispredict_o, PCcorrect_o, branchcnt_o, mispredcnt_o
  );

  modport slave (
    input  pc_f_i, predtaken_f_i, predtarget_f_i, btbhit_f_i, phtidx_f_i,
    input  StallD_i, FlushD_i, FlushE_i,
    input  op_e_i, taken_e_i, target_e_i,
    output BTBwriteaddress_o, BTBwritedata_o, BTB_we_o,
    output PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
    output Mispredict_o, PCcorrect_o, branchcnt_o, mispredcnt_o
  );
endinterface

// File: rtl/ucsbece154b_bpred_stage.sv
// ---------------------------------------------------------------------------
// ucsbece154b_bpred_stage
// One pipeline register for the prediction payload plus its valid bit.
//   clk, reset_i : clock, asynchronous active-high reset
//   stall        : hold current contents (ignored when flush is high)
//   flush        : clear valid (highest priority)
//   valid_in     : valid bit loaded when neither flush nor stall
//   data_in      : payload loaded alongside valid_in
//   valid, data  : registered contents
// ---------------------------------------------------------------------------
module ucsbece154b_bpred_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its sources, independent of block ordering.
  // NOTE: the payload is reset too, not only valid; nothing downstream would
  // see it while valid is low, but it keeps reset state fully defined.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// ---------------------------------------------------------------------------
// ucsbece154b_branch_resolve
// Carries each fetched instruction's prediction through the D and E pipeline
// registers, compares it with the outcome resolved in Execute and drives:
//   - predictor update : BTB write, PHT counter update, GHR clear
//   - redirect         : Mispredict_o / PCcorrect_o to fetch and hazard unit
//   - statistics       : saturating branch / mispredict counters
// Ports:
//   clk, reset_i : clock, asynchronous active-high reset
//   bus          : ucsbece154b_branch_resolve_if.slave (all other signals)
// Every update/redirect output is combinational from the E register and the
// E-stage inputs, forced to zero while the E slot is empty.
// ---------------------------------------------------------------------------
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int CNT_WIDTH       = 32
) (
  input logic                          clk,
  input logic                          reset_i,
  ucsbece154b_branch_resolve_if.slave  bus
);

  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam int PW        = payload_width(NUM_GHR_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PW-1:0] payload_f, payload_d, payload_e;
  logic          valid_d, valid_e;

  assign payload_f = {bus.pc_f_i, bus.predtaken_f_i, bus.predtarget_f_i,
                      bus.btbhit_f_i, bus.phtidx_f_i};

  // D always captures a real fetch slot; only flush can empty it.
  ucsbece154b_bpred_stage #(.WIDTH(PW)) stage_d (
    .clk      (clk),
    .reset_i  (reset_i),
    .stall    (bus.StallD_i),
    .flush    (bus.FlushD_i),
    .valid_in (1'b1),
    .data_in  (payload_f),
    .valid    (valid_d),
    .data     (payload_d)
  );

  // E never stalls; a load-use stall holds D while E takes a bubble.
  ucsbece154b_bpred_stage #(.WIDTH(PW)) stage_e (
    .clk      (clk),
    .reset_i  (reset_i),
    .stall    (1'b0),
    .flush    (bus.FlushE_i),
    .valid_in (valid_d),
    .data_in  (payload_d),
    .valid    (valid_e),
    .data     (payload_e)
  );

  logic [31:0]             pc_e;
  logic                    predtaken_e;
  logic [31:0]             predtarget_e;
  logic                    btbhit_e;
  logic [NUM_GHR_BITS-1:0] phtidx_e;

  assign {pc_e, predtaken_e, predtarget_e, btbhit_e, phtidx_e} = payload_e;

  logic is_b, is_j, is_cf, act, target_diff, mispredict;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    is_b        = 1'b0;
    is_j        = 1'b0;
    mispredict  = 1'b0;
    case (classify_op(bus.op_e_i))
      OP_BRANCH: is_b = 1'b1;
      OP_JUMP:   is_j = 1'b1;
      default:   ;
    endcase
    is_cf       = is_b | is_j;
    act         = is_j | (is_b & bus.taken_e_i);
    target_diff = (predtarget_e != bus.target_e_i);
    if (valid_e) begin
      if (is_cf) begin
        // Wrong direction, or right direction (taken) but stale target.
        mispredict = (predtaken_e != act) | (act & predtaken_e & target_diff);
      end else begin
        // A non-branch that hit in the BTB was steered away by an alias.
        mispredict = predtaken_e;
      end
    end
  end

  assign bus.Mispredict_o      = mispredict;
  assign bus.PCcorrect_o       = valid_e ? (act ? bus.target_e_i : pc_e + 32'd4) : 32'd0;
  assign bus.BTB_we_o          = valid_e & act & (~btbhit_e | target_diff);
  assign bus.BTBwriteaddress_o = valid_e ? pc_e[BTB_IDX_W+1:2] : '0;
  assign bus.BTBwritedata_o    = valid_e ? bus.target_e_i : 32'd0;
  assign bus.PHTwe_o           = valid_e & is_b;
  assign bus.PHTincrement_o    = valid_e & bus.taken_e_i;
  // The PHT index is the one captured at fetch; the GHR has moved since.
  assign bus.PHTwriteaddress_o = valid_e ? phtidx_e : '0;
  assign bus.GHRreset_o        = mispredict & is_b;

  logic [CNT_WIDTH-1:0] branch_cnt, mispred_cnt;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (valid_e && is_cf && branch_cnt != CNT_MAX)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mispredict && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.branchcnt_o  = branch_cnt;
  assign bus.mispredcnt_o = mispred_cnt;

endmodule

// File: doc/ucsbece154b_branch_resolve.md
Name: ucsbece154b_branch_resolve

Overview:
- Execute-side counterpart of the branch predictor. Carries each fetched instruction's prediction metadata through the F->D->E pipeline registers and compares it with the resolved outcome in Execute.
- Drives the predictor's update port: BTB write, PHT counter update and GHR reset. Also drives the misprediction redirect/flush request to fetch and the hazard unit.
- Keeps branch and mispredict performance counters.

Parameters:
- NUM_BTB_ENTRIES, 32, BTB depth; write index is pc[$clog2(NUM_BTB_ENTRIES)+1:2].
- NUM_GHR_BITS, 5, PHT index width; must match the predictor.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- pc_f_i  in  32  fetch PC.
- predtaken_f_i  in  1  predictor BranchTaken for pc_f_i.
- predtarget_f_i  in  32  predictor BTB target for pc_f_i.
- btbhit_f_i  in  1  BTB valid and tag match for pc_f_i.
- phtidx_f_i  in  NUM_GHR_BITS  predictor PHT read address for pc_f_i.
- StallD_i  in  1  hold the D register.
- FlushD_i  in  1  invalidate the D register.
- FlushE_i  in  1  load a bubble into the E register.
- op_e_i  in  7  opcode of the instruction in Execute.
- taken_e_i  in  1  resolved direction; ignored for non-branches, jal/jalr are always taken.
- target_e_i  in  32  resolved target.
- BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  BTB write index.
- BTBwritedata_o  out  32  BTB write target.
- BTB_we_o  out  1  BTB write enable.
- PHTwe_o  out  1  PHT write enable.
- PHTincrement_o  out  1  PHT increment (1) / decrement (0).
- PHTwriteaddress_o  out  NUM_GHR_BITS  PHT write index.
- GHRreset_o  out  1  GHR clear.
- Mispredict_o  out  1  redirect request.
- PCcorrect_o  out  32  corrected next PC.
- branchcnt_o  out  CNT_WIDTH  resolved control-flow count.
- mispredcnt_o  out  CNT_WIDTH  mispredict count.

Behaviour:
- Pipeline payload per stage: valid, pc, predtaken, predtarget, btbhit, phtidx.
- D register update, per cycle, in priority order:
  - FlushD: valid=0.
  - StallD: hold.
  - Otherwise: load the F inputs with valid=1.
- E register update, per cycle:
  - FlushE: valid=0.
  - Otherwise: load from D.
- Reset: asynchronous, clears both valids and both counters immediately. All outputs read 0 during reset and in the cycle after release. Reset mid-operation drops in-flight payloads without issuing updates.
- All update, redirect and GHR outputs are combinational from E-register contents and E-stage inputs. They are gated by valid_e; the predictor commits them at the next clk edge.
- Decode of op_e_i: isB = branch op; isJ = jal or jalr; act = isJ | (isB & taken_e_i).
- Mispredict_o asserts when valid_e and any of:
  - (isB|isJ) & (predtaken != act).
  - (isB|isJ) & act & predtaken & (predtarget != target_e_i).
  - !(isB|isJ) & predtaken (BTB alias).
- PCcorrect_o = act ? target_e_i : pc_e+4, 32-bit wrap.
- BTB_we_o = valid_e & act & (!btbhit | predtarget != target_e_i).
  - BTBwriteaddress_o = pc_e index bits.
  - BTBwritedata_o = target_e_i.
- PHTwe_o = valid_e & isB; PHTincrement_o = taken_e_i; PHTwriteaddress_o = phtidx_e, the index captured at fetch, not recomputed.
- GHRreset_o = Mispredict_o & isB.
- Counters, registered:
  - branchcnt_o increments when valid_e & (isB|isJ).
  - mispredcnt_o increments on Mispredict_o.
  - Both saturate at all-ones.
- Simultaneous StallD & FlushE, the load-use case: D holds while E gets a bubble. The instruction in D is not lost or duplicated.
- Mispredict_o is not gated by the flush inputs of the same cycle. The hazard unit responds next edge with FlushD/FlushE.

Decomposition:
- Opcode constants (instr_branch_op, instr_jal_op, instr_jalr_op) come from ucsbece154b_defines.vh; no new constants. Add a localparam for the payload width there if it is shared.
- One sub-module: ucsbece154b_bpred_stage, the payload register with valid, stall, flush and asynchronous reset. It is instantiated for D (stall unused in E) and for E.

Test Plan:
- Branch at pc 0x100, predtaken=0, btbhit=0, taken_e=1, target 0x80 -> E cycle: Mispredict=1, PCcorrect=0x80, BTB_we=1, addr=0, data=0x80, PHTwe=1, inc=1, GHRreset=1; branchcnt=1, mispredcnt=1.
- Same branch, predtaken=1, predtarget=0x80, btbhit=1, taken_e=1 -> Mispredict=0, BTB_we=0, PHTwe=1, inc=1, addr=phtidx captured at F.
- jalr at 0x200, predtaken=1, predtarget=0x300, actual 0x340 -> Mispredict=1, PCcorrect=0x340, BTB_we=1, PHTwe=0, GHRreset=0.
- ALU op at 0x10C with predtaken=1 -> Mispredict=1, PCcorrect=0x110, no BTB or PHT write.
- StallD=1 & FlushE=1 for one cycle with a branch in D -> E shows a bubble (no outputs); the branch resolves exactly once the next cycle.
- Assert reset_i asynchronously mid-cycle with a valid branch in E -> all outputs drop to 0 without a clk edge; counters read 0.
